regfile_seq: RTL
================

# regfile_seq

Command sequencer for the 8 × 4-bit two-read/one-write register file. It accepts one register-transfer command at a time over a valid/ready handshake, drives the read addresses, and samples both read ports. It computes a 4-bit result and performs the write-back through the single write port. It is the only master of the register file's address, data and write controls.

## Interface
Parameters: none. Widths are fixed by the register file: 8 registers, 4-bit data.

- CLK  in  1  system clock, rising edge
- CLRN  in  1  reset, synchronous, active-low
- CMD_VALID  in  1  command present
- CMD_READY  out  1  sequencer in IDLE and able to accept a command
- CMD_OP  in  3  opcode: 000 LOAD, 001 MOV, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 XOR, 111 SWAP
- CMD_DST  in  3  destination register
- CMD_SRCP  in  3  source register P
- CMD_SRCQ  in  3  source register Q
- CMD_IMM  in  4  immediate (LOAD only)
- RP  out  3  register file P read address
- RQ  out  3  register file Q read address
- DATAP  in  4  register file P read data (combinational)
- DATAQ  in  4  register file Q read data (combinational)
- WA  out  3  write address
- LD_DATA  out  4  write data
- WR  out  1  write strobe, one cycle per write
- DONE  out  1  one-cycle completion pulse
- RESULT  out  4  result of last command, held until the next DONE
- CARRY  out  1  carry/borrow flag, held until the next DONE
- ZERO  out  1  RESULT == 0, held until the next DONE
- ERR  out  1  last command illegal, held until the next DONE

## Operation
- FSM states: IDLE, READ, EXEC, WRITE, WRITE2 (SWAP only), FIN.
- IDLE:
  - CMD_READY=1.
  - On CMD_VALID&&CMD_READY, latch OP/DST/SRCP/SRCQ/IMM and go to READ.
- READ: RP=latched SRCP, RQ=latched SRCQ; go to EXEC.
- EXEC:
  - Register DATAP/DATAQ into capture regs A/B and compute the result.
  - SWAP goes to WRITE; an illegal op goes to FIN with no write; all others go to WRITE.
- WRITE: WR=1, WA=DST, LD_DATA=result.
  - SWAP: WA=SRCP, LD_DATA=B; next state WRITE2.
  - All other ops: next state FIN.
- WRITE2: WR=1, WA=SRCQ, LD_DATA=A; go to FIN.
- FIN: DONE=1 and flags update; go to IDLE.
- RP/RQ stay at the latched sources from READ through FIN, so the captured values stay stable.
- Result rules (4-bit, wrap-around):
  - LOAD = IMM; MOV = A.
  - ADD = A+B, CARRY = bit 4 of the 5-bit sum.
  - SUB = A−B, CARRY = borrow (A<B).
  - AND, OR, XOR bitwise; CARRY=0.
  - SWAP: RESULT=A, CARRY=0.
- ZERO = (RESULT==0). On ERR: RESULT=0, CARRY=0, ZERO=0.
- DST equal to a source is legal: the sources are captured before the write.
- SWAP with SRCP==SRCQ performs two writes of the same value; the register is unchanged.
- CMD_VALID outside IDLE is ignored. The command is not consumed until CMD_READY=1.

## Timing
- Reset (CLRN=0 at an edge): state=IDLE; CMD_READY=1; WR=0; DONE=0; RP=RQ=WA=0; LD_DATA=0; RESULT=0; CARRY=0; ZERO=0; ERR=0.
- Reset mid-command aborts it. No write occurs after the reset edge, and no DONE is produced.
- Handshake at edge 0 gives READ in cycle 1, EXEC in 2, WRITE (WR=1) in 3, DONE in 4. SWAP takes WRITE in 3, WRITE2 in 4, DONE in 5.
- CMD_READY is 0 from cycle 1 through FIN and returns to 1 in the cycle after DONE.
- Throughput: one command per 5 cycles (6 for SWAP).
- WR is never asserted in two consecutive cycles except in the WRITE→WRITE2 pair.
- All outputs are registered. None depends combinationally on CMD_* or DATAP/DATAQ.

## Configuration
- REGFILE_SEQ_SWAP_EN defined: opcode 111 executes SWAP as above, with WRITE2 present.
- REGFILE_SEQ_SWAP_EN undefined:
  - Opcode 111 is illegal: EXEC→FIN, no WR, DONE with ERR=1.
  - The WRITE2 state and the B-to-port write path are not built.

## Structure
- Shared package regfile_pkg holds:
  - the opcode localparams (OP_LOAD … OP_SWAP);
  - the state encoding;
  - REG_ADDR_W=3 and REG_DATA_W=4.
- One sub-module, regfile_seq_alu: combinational, takes op/A/B/imm and returns result/carry/zero/illegal. Its illegal output depends on REGFILE_SEQ_SWAP_EN.
- The FSM, latches and output registers live in regfile_seq.

## Test plan
- Reset: hold CLRN=0 for 2 cycles with CMD_VALID=1 → CMD_READY=1, WR=0, DONE=0, all outputs 0. No command is accepted until CLRN=1.
- LOAD then ADD: LOAD r1←9, LOAD r2←8, then ADD r3=r1+r2.
  - The ADD writes WA=3, LD_DATA=1 in its WRITE cycle.
  - Its DONE shows RESULT=1, CARRY=1, ZERO=0.
  - DONE arrives exactly 4 cycles after the handshake.
- SUB borrow and zero: r1=5, r2=5; SUB r4=r1−r2 → RESULT=0, ZERO=1, CARRY=0. Then SUB r4=r2−(r0=7) → RESULT=14, CARRY=1.
- SWAP: r5=3, r6=12, SWAP(5,6).
  - With REGFILE_SEQ_SWAP_EN: WR in two consecutive cycles (WA=5/LD_DATA=12, then WA=6/LD_DATA=3), DONE at cycle 5.
  - Without it: no WR, DONE with ERR=1.
- Back-pressure and abort:
  - CMD_VALID held high with a changing CMD_OP during a busy period → only the command present when CMD_READY=1 executes.
  - Drop CLRN to 0 in the EXEC cycle → no WR, no DONE; RESULT=0 after the reset edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the register-file command sequencer: widths, opcodes, FSM state encoding.
package regfile_pkg;

   localparam int REG_ADDR_W = 3;
   localparam int REG_DATA_W = 4;

   localparam logic [2:0] OP_LOAD = 3'b000;
   localparam logic [2:0] OP_MOV  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_OR   = 3'b101;
   localparam logic [2:0] OP_XOR  = 3'b110;
   localparam logic [2:0] OP_SWAP = 3'b111;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_READ   = 3'd1;
   localparam logic [2:0] ST_EXEC   = 3'd2;
   localparam logic [2:0] ST_WRITE  = 3'd3;
   localparam logic [2:0] ST_WRITE2 = 3'd4;
   localparam logic [2:0] ST_FIN    = 3'd5;

endpackage

// File: rtl/regfile_seq_alu.sv
// Combinational result/flag logic for one sequencer command.
// Opcode 111 is SWAP when REGFILE_SEQ_SWAP_EN is defined, otherwise it is flagged illegal.
module regfile_seq_alu
   import regfile_pkg::*;
(
   input  logic [2:0] op,
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic [3:0] imm,
   output logic [3:0] result,
   output logic       carry,
   output logic       zero,
   output logic       illegal
);

   logic [4:0] sum;
   logic [4:0] diff;

   assign sum  = {1'b0, a} + {1'b0, b};
   assign diff = {1'b0, a} - {1'b0, b};

   always_comb begin
      result  = '0;
      carry   = 1'b0;
      illegal = 1'b0;
      case (op)
         OP_LOAD: result = imm;
         OP_MOV:  result = a;
         OP_ADD:  begin result = sum[3:0];  carry = sum[4];  end
         OP_SUB:  begin result = diff[3:0]; carry = (a < b); end
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         default: begin
`ifdef REGFILE_SEQ_SWAP_EN
            result  = a;
`else
            illegal = 1'b1;
`endif
         end
      endcase
   end

   // An illegal command reports all-zero flags, including ZERO.
   assign zero = !illegal && (result == '0);

endmodule

// File: rtl/regfile_seq.sv
// Command sequencer and sole master of an 8x4 two-read/one-write register file.
// Optional SWAP opcode is built when REGFILE_SEQ_SWAP_EN is defined.
module regfile_seq
   import regfile_pkg::*;
(
   input  logic       CLK,
   input  logic       CLRN,
   input  logic       CMD_VALID,
   output logic       CMD_READY,
   input  logic [2:0] CMD_OP,
   input  logic [2:0] CMD_DST,
   input  logic [2:0] CMD_SRCP,
   input  logic [2:0] CMD_SRCQ,
   input  logic [3:0] CMD_IMM,
   output logic [2:0] RP,
   output logic [2:0] RQ,
   input  logic [3:0] DATAP,
   input  logic [3:0] DATAQ,
   output logic [2:0] WA,
   output logic [3:0] LD_DATA,
   output logic       WR,
   output logic       DONE,
   output logic [3:0] RESULT,
   output logic       CARRY,
   output logic       ZERO,
   output logic       ERR,
   output logic [2:0] state_dbg
);

   // Handshake: a command is taken on a rising edge where CMD_VALID && CMD_READY;
   // CMD_READY is high only in IDLE, so CMD_VALID in any other state is ignored.
   logic [2:0] state;
   logic [2:0] op_r;
   logic [2:0] dst_r;
   logic [2:0] srcq_r;
   logic [3:0] imm_r;
   logic [3:0] res_r;
   logic       carry_r;
   logic       zero_r;
`ifdef REGFILE_SEQ_SWAP_EN
   logic [3:0] a_r;
`endif

   logic [3:0] alu_result;
   logic       alu_carry;
   logic       alu_zero;
   logic       alu_illegal;

   regfile_seq_alu u_alu (
      .op      (op_r),
      .a       (DATAP),
      .b       (DATAQ),
      .imm     (imm_r),
      .result  (alu_result),
      .carry   (alu_carry),
      .zero    (alu_zero),
      .illegal (alu_illegal)
   );

   assign state_dbg = state;

   always_ff @(posedge CLK) begin
      if (!CLRN) begin
         state     <= ST_IDLE;
         CMD_READY <= 1'b1;
         WR        <= 1'b0;
         DONE      <= 1'b0;
         RP        <= '0;
         RQ        <= '0;
         WA        <= '0;
         LD_DATA   <= '0;
         RESULT    <= '0;
         CARRY     <= 1'b0;
         ZERO      <= 1'b0;
         ERR       <= 1'b0;
         op_r      <= '0;
         dst_r     <= '0;
         srcq_r    <= '0;
         imm_r     <= '0;
         res_r     <= '0;
         carry_r   <= 1'b0;
         zero_r    <= 1'b0;
`ifdef REGFILE_SEQ_SWAP_EN
         a_r       <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (CMD_VALID) begin
                  op_r      <= CMD_OP;
                  dst_r     <= CMD_DST;
                  srcq_r    <= CMD_SRCQ;
                  imm_r     <= CMD_IMM;
                  // Read addresses hold from READ through FIN so DATAP/DATAQ stay stable.
                  RP        <= CMD_SRCP;
                  RQ        <= CMD_SRCQ;
                  CMD_READY <= 1'b0;
                  state     <= ST_READ;
               end
            end
            ST_READ: state <= ST_EXEC;
            ST_EXEC: begin
               res_r   <= alu_result;
               carry_r <= alu_carry;
               zero_r  <= alu_zero;
`ifdef REGFILE_SEQ_SWAP_EN
               a_r     <= DATAP;
`endif
               if (alu_illegal) begin
                  DONE   <= 1'b1;
                  RESULT <= '0;
                  CARRY  <= 1'b0;
                  ZERO   <= 1'b0;
                  ERR    <= 1'b1;
                  state  <= ST_FIN;
               end else begin
                  WR <= 1'b1;
                  if (op_r == OP_SWAP) begin
                     WA      <= RP;
                     LD_DATA <= DATAQ;
                  end else begin
                     WA      <= dst_r;
                     LD_DATA <= alu_result;
                  end
                  state <= ST_WRITE;
               end
            end
            ST_WRITE: begin
`ifdef REGFILE_SEQ_SWAP_EN
               if (op_r == OP_SWAP) begin
                  WR      <= 1'b1;
                  WA      <= srcq_r;
                  LD_DATA <= a_r;
                  state   <= ST_WRITE2;
               end else
`endif
               begin
                  WR     <= 1'b0;
                  DONE   <= 1'b1;
                  RESULT <= res_r;
                  CARRY  <= carry_r;
                  ZERO   <= zero_r;
                  ERR    <= 1'b0;
                  state  <= ST_FIN;
               end
            end
`ifdef REGFILE_SEQ_SWAP_EN
            ST_WRITE2: begin
               WR     <= 1'b0;
               DONE   <= 1'b1;
               RESULT <= res_r;
               CARRY  <= carry_r;
               ZERO   <= zero_r;
               ERR    <= 1'b0;
               state  <= ST_FIN;
            end
`endif
            ST_FIN: begin
               DONE      <= 1'b0;
               CMD_READY <= 1'b1;
               state     <= ST_IDLE;
            end
            default: begin
               WR        <= 1'b0;
               DONE      <= 1'b0;
               CMD_READY <= 1'b1;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
